// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op codes, wide-op decode and drain FSM types shared by the result drain
package alu_pkg;

    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_SHR  = 5'b00011;
    localparam logic [4:0] OP_SHRA = 5'b00100;
    localparam logic [4:0] OP_SHL  = 5'b00101;
    localparam logic [4:0] OP_ROR  = 5'b00110;
    localparam logic [4:0] OP_ROL  = 5'b00111;
    localparam logic [4:0] OP_NEG  = 5'b01000;
    localparam logic [4:0] OP_NOT  = 5'b01001;
    localparam logic [4:0] OP_ADD  = 5'b01010;
    localparam logic [4:0] OP_SUB  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01100;
    localparam logic [4:0] OP_DIV  = 5'b01101;

    localparam logic BEAT_LO = 1'b0;
    localparam logic BEAT_HI = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } drain_state_t;

    // Only multiply and divide produce a meaningful HI word.
    function automatic logic is_wide_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - DEPTH-entry synchronous FIFO with first-word head output
module result_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_result_drain.sv
// rtl/alu_result_drain.sv - buffers ALU results and drains them as LO/HI bus beats; ALU_RESULT_FLAGS_EN adds zero/neg flags
module alu_result_drain
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cap_valid,
    output logic                cap_ready,
    input  logic [4:0]          cap_op,
    input  logic [2*DATA_W-1:0] cap_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_hi,
    output logic                out_last,
`ifdef ALU_RESULT_FLAGS_EN
    output logic                out_zero,
    output logic                out_neg,
`endif
    output logic                busy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef ALU_RESULT_FLAGS_EN
    localparam int ENTRY_W = 2*DATA_W + 3;
`else
    localparam int ENTRY_W = 2*DATA_W + 1;
`endif

    drain_state_t        state_q;
    drain_state_t        state_d;
    logic [ENTRY_W-1:0]  push_entry;
    logic [ENTRY_W-1:0]  head;
    logic [CNT_W-1:0]    count;
    logic                full;
    logic                push;
    logic                pop;
    logic                cap_wide;
    logic                head_wide;
    logic [DATA_W-1:0]   head_lo;
    logic [DATA_W-1:0]   head_hi;
    logic                more_after_pop;

    assign cap_ready = !full;
    assign push      = cap_valid && cap_ready;
    assign cap_wide  = is_wide_op(cap_op);

`ifdef ALU_RESULT_FLAGS_EN
    logic cap_zero;
    logic cap_neg;

    assign cap_zero   = cap_wide ? (cap_data == '0) : (cap_data[DATA_W-1:0] == '0);
    assign cap_neg    = cap_wide ? cap_data[2*DATA_W-1] : cap_data[DATA_W-1];
    assign push_entry = {cap_zero, cap_neg, cap_wide, cap_data};
    assign out_zero   = out_valid && head[2*DATA_W+2];
    assign out_neg    = out_valid && head[2*DATA_W+1];
`else
    assign push_entry = {cap_wide, cap_data};
`endif

    assign head_wide = head[2*DATA_W];
    assign head_hi   = head[2*DATA_W-1:DATA_W];
    assign head_lo   = head[DATA_W-1:0];

    // A same-cycle capture refills the buffer, so the next LO beat follows without a gap.
    assign more_after_pop = (count > CNT_W'(1)) || push;

    assign busy = (count != '0) || (state_q != ST_IDLE);

    result_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Beat outputs come from the held head entry, so they stay stable under backpressure.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_hi    = BEAT_LO;
        out_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count != '0) begin
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                out_valid = 1'b1;
                out_data  = head_lo;
                out_last  = !head_wide;
                if (out_ready) begin
                    if (head_wide) begin
                        state_d = ST_HI;
                    end else begin
                        pop     = 1'b1;
                        state_d = more_after_pop ? ST_LO : ST_IDLE;
                    end
                end
            end
            ST_HI: begin
                out_valid = 1'b1;
                out_data  = head_hi;
                out_hi    = BEAT_HI;
                out_last  = 1'b1;
                if (out_ready) begin
                    pop     = 1'b1;
                    state_d = more_after_pop ? ST_LO : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
